// File: rtl/mul_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mul_share_ctrl
// Purpose  : Shares one multi-cycle integer multiplier between two requesters.
//            Round-robin grant, operand hold for the whole computation,
//            watchdog-bounded wait for completion, and a valid/ready
//            response channel carrying result, tag and source index.
// Revision : 1.0 - initial release
// ============================================================================
module mul_share_ctrl #(
    parameter int WIDTH   = 32,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 48
) (
    input  logic             i_clk,
    input  logic             i_rst_n,

    // Requester 0
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic [TAG_W-1:0] i_req0_tag,

    // Requester 1
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    input  logic [TAG_W-1:0] i_req1_tag,

    // Multiplier interface
    output logic             o_mul_valid,
    output logic [WIDTH-1:0] o_mul_a,
    output logic [WIDTH-1:0] o_mul_b,
    input  logic             i_mul_valid,
    input  logic [WIDTH-1:0] i_mul_result,

    // Response channel
    output logic             o_resp_valid,
    input  logic             i_resp_ready,
    output logic [WIDTH-1:0] o_resp_result,
    output logic [TAG_W-1:0] o_resp_tag,
    output logic             o_resp_src,
    output logic             o_resp_err,

    output logic             o_busy
);

    // Watchdog counter only ever needs to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_WD_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_WD_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t           r_state;
    logic             r_rr_ptr;       // requester favoured on a tie
    logic [CNT_W-1:0] r_wd_cnt;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [TAG_W-1:0] r_tag;
    logic             r_src;
    logic             r_mul_valid;
    logic             r_resp_valid;
    logic [WIDTH-1:0] r_resp_result;
    logic             r_resp_err;
    logic             r_busy;

    logic             w_grant_any;
    logic             w_grant_sel;
    logic             w_accept;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [TAG_W-1:0] w_sel_tag;
    logic             w_wd_expired;

    // Arbitration: a lone valid requester wins; on a tie the pointer decides.
    always_comb begin
        w_grant_any = 1'b0;
        w_grant_sel = 1'b0;
        if (i_req0_valid && i_req1_valid) begin
            w_grant_any = 1'b1;
            w_grant_sel = r_rr_ptr;
        end else if (i_req0_valid) begin
            w_grant_any = 1'b1;
            w_grant_sel = 1'b0;
        end else if (i_req1_valid) begin
            w_grant_any = 1'b1;
            w_grant_sel = 1'b1;
        end
    end

    // Accept only from IDLE; suppressed while reset is asserted so that no
    // handshake can complete on a cycle whose state update is discarded.
    assign w_accept     = (r_state == ST_IDLE) && i_rst_n && w_grant_any;
    assign o_req0_ready = w_accept && !w_grant_sel;
    assign o_req1_ready = w_accept &&  w_grant_sel;

    assign w_sel_a      = w_grant_sel ? i_req1_a   : i_req0_a;
    assign w_sel_b      = w_grant_sel ? i_req1_b   : i_req0_b;
    assign w_sel_tag    = w_grant_sel ? i_req1_tag : i_req0_tag;
    assign w_wd_expired = (r_wd_cnt == c_WD_LAST);

    // Controller sequencing: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_rr_ptr      <= 1'b0;
            r_wd_cnt      <= '0;
            r_op_a        <= '0;
            r_op_b        <= '0;
            r_tag         <= '0;
            r_src         <= 1'b0;
            r_mul_valid   <= 1'b0;
            r_resp_valid  <= 1'b0;
            r_resp_result <= '0;
            r_resp_err    <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            // Start strobe lasts exactly the ISSUE cycle.
            r_mul_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op_a      <= w_sel_a;
                        r_op_b      <= w_sel_b;
                        r_tag       <= w_sel_tag;
                        r_src       <= w_grant_sel;
                        r_rr_ptr    <= ~w_grant_sel;
                        r_mul_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Done may still be high from the previous operation,
                    // so it is deliberately not looked at here.
                    r_wd_cnt <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_wd_cnt <= r_wd_cnt + c_WD_ONE;
                    if (i_mul_valid) begin
                        r_resp_result <= i_mul_result;
                        r_resp_err    <= 1'b0;
                        r_resp_valid  <= 1'b1;
                        r_state       <= ST_RESP;
                    end else if (w_wd_expired) begin
                        r_resp_result <= '0;
                        r_resp_err    <= 1'b1;
                        r_resp_valid  <= 1'b1;
                        r_state       <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Returning to IDLE (not accepting here) guarantees a
                    // bubble cycle between responses and new grants.
                    if (i_resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_state      <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mul_valid   = r_mul_valid;
    assign o_mul_a       = r_op_a;
    assign o_mul_b       = r_op_b;
    assign o_resp_valid  = r_resp_valid;
    assign o_resp_result = r_resp_result;
    assign o_resp_tag    = r_tag;
    assign o_resp_src    = r_src;
    assign o_resp_err    = r_resp_err;
    assign o_busy        = r_busy;

endmodule
`default_nettype wire
